// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU adder scheduler.
// The tag index is sized for the largest supported requester count (8).
package fpu_arb_pkg;

    localparam int TAG_IDX_W = 3;

    localparam logic [1:0] FPU_OK  = 2'b00;
    localparam logic [1:0] FPU_NAN = 2'b01;
    localparam logic [1:0] FPU_INF = 2'b10;
    localparam logic [1:0] FPU_NUL = 2'b11;

    typedef struct packed {
        logic                 vld;
        logic [TAG_IDX_W-1:0] idx;
    } fpu_tag_t;

endpackage

// File: rtl/fpu_tag_pipe.sv
// Fixed-depth shift register of in-flight tags with synchronous clear.
// The head stage lines up with the adder's result-valid strobe.
module fpu_tag_pipe
    import fpu_arb_pkg::*;
#(
    parameter int  LATENCY = 6,
    parameter type tag_t   = fpu_tag_t
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_head
);

    tag_t stages [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_head = stages[LATENCY-1];

endmodule

// File: rtl/fpu_add_scheduler.sv
// Round-robin scheduler sharing one pipelined FP adder among N_REQ clients.
// Optional per-requester grant counters are enabled by FPU_ARB_PERF_CNT_EN.
module fpu_add_scheduler
    import fpu_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_vld,
    input  logic [N_REQ*32-1:0]   req_a,
    input  logic [N_REQ*32-1:0]   req_b,
    output logic [N_REQ-1:0]      req_rdy,
    output logic [31:0]           fpu_a,
    output logic [31:0]           fpu_b,
    output logic                  fpu_arg_vld,
    input  logic [31:0]           fpu_result,
    input  logic [1:0]            fpu_state,
    input  logic                  fpu_res_vld,
    output logic [N_REQ-1:0]      rsp_vld,
    output logic [31:0]           rsp_result,
    output logic [1:0]            rsp_state,
    output logic                  err_orphan,
    output logic                  err_missing
`ifdef FPU_ARB_PERF_CNT_EN
    ,
    output logic [N_REQ*16-1:0]   grant_cnt
`endif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] issue_idx;
    logic             grant_any;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    int               target;
    fpu_tag_t         tag_in;
    fpu_tag_t         tag_head;

    // Search outward from rr_ptr; the first valid requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        sel_a     = '0;
        sel_b     = '0;
        target    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            target = int'(rr_ptr) + k;
            if (target >= N_REQ) begin
                target = target - N_REQ;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!grant_any && req_vld[i] && (i == target)) begin
                    grant_any = 1'b1;
                    grant_idx = IDX_W'(i);
                    sel_a     = req_a[32*i +: 32];
                    sel_b     = req_b[32*i +: 32];
                end
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_rdy[i] = grant_any && (grant_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_a       <= '0;
            fpu_b       <= '0;
            fpu_arg_vld <= 1'b0;
            issue_idx   <= '0;
            rr_ptr      <= '0;
        end else begin
            fpu_arg_vld <= grant_any;
            if (grant_any) begin
                fpu_a     <= sel_a;
                fpu_b     <= sel_b;
                issue_idx <= grant_idx;
                rr_ptr    <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // The tag enters alongside the operand pair, so its head meets the result.
    assign tag_in.vld = fpu_arg_vld;
    assign tag_in.idx = TAG_IDX_W'(issue_idx);

    fpu_tag_pipe #(
        .LATENCY (LATENCY),
        .tag_t   (fpu_tag_t)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .tag_in   (tag_in),
        .tag_head (tag_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld     <= '0;
            rsp_result  <= '0;
            rsp_state   <= FPU_OK;
            err_orphan  <= 1'b0;
            err_missing <= 1'b0;
        end else begin
            rsp_vld <= '0;
            if (tag_head.vld && fpu_res_vld) begin
                for (int i = 0; i < N_REQ; i++) begin
                    rsp_vld[i] <= (tag_head.idx == TAG_IDX_W'(i));
                end
                rsp_result <= fpu_result;
                rsp_state  <= fpu_state;
            end
            if (fpu_res_vld && !tag_head.vld) begin
                err_orphan <= 1'b1;
            end
            if (tag_head.vld && !fpu_res_vld) begin
                err_missing <= 1'b1;
            end
        end
    end

`ifdef FPU_ARB_PERF_CNT_EN
    logic [15:0] cnt [N_REQ];

    // Saturating so a long-running client never wraps back to a small count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_vld[i] && req_rdy[i] && (cnt[i] != 16'hFFFF)) begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_cnt[16*i +: 16] = cnt[i];
        end
    end
`endif

endmodule
